// File: rtl/serial_adder_if.sv
// Handshake and data bundle for the bit-serial adder.
// The master issues start with operands; the slave reports busy/done and the result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell (two half adders and an OR)
// processes one bit per cycle, LSB first, with the carry held in a register.
// A start in IDLE captures the operands; the result is valid when done pulses
// and holds until the next accepted start.

// One-bit half adder cell.
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             c_q,      c_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  logic ha0_sum, ha0_carry;
  logic ha1_sum, ha1_carry;
  logic bit_sum, bit_carry;

  // Full adder built from two half adders; ha0 adds the operand bits, ha1 folds in the carry.
  half_adder u_ha0 (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .sum   (ha0_sum),
    .carry (ha0_carry)
  );

  half_adder u_ha1 (
    .a     (ha0_sum),
    .b     (c_q),
    .sum   (ha1_sum),
    .carry (ha1_carry)
  );

  assign bit_sum   = ha1_sum;
  assign bit_carry = ha0_carry | ha1_carry;

  // Next-state logic: load on start, shift one bit per RUN cycle, single-cycle DONE.
  always_comb begin
    // NOTE: every signal assigned here gets a hold default first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    c_d      = c_q;
    cnt_d    = cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          sum_sh_d = '0;
          c_d      = 1'b0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Shift right and drop the new bit into the MSB; works for WIDTH=1 too.
        sum_sh_d            = sum_sh_q >> 1;
        sum_sh_d[WIDTH-1]   = bit_sum;
        c_d                 = bit_carry;
        a_sh_d              = a_sh_q >> 1;
        b_sh_d              = b_sh_q >> 1;
        cnt_d               = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset that also aborts any operation in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of its neighbours.
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_sh_q;
  assign bus.carry = c_q;

endmodule
